// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: check-width helper, H-matrix column generator
// and the decoder result record used by the lockstep checker.
package ecc_pkg;

    // Upper bound on data width; the result mask is sized to it so the
    // record can be compared as a whole between the two decoders.
    localparam int ECC_MASK_W = 64;

    typedef struct packed {
        logic [ECC_MASK_W-1:0] mask;  // correction mask, 1 = flip this data bit
        logic                  sbit;  // single-bit (correctable) error
        logic                  dbit;  // double-bit (uncorrectable) error
    } dec_res_t;

    // Smallest check width p with 2^(p-1) >= data_width + p
    // (extended Hamming: p-1 position bits plus one overall-parity bit).
    function automatic int parity_width(input int data_width);
        int p;
        p = 2;
        while ((1 << (p - 1)) < data_width + p) p++;
        return p;
    endfunction

    // H-matrix column for data bit idx: the idx-th non-power-of-two
    // Hamming position (3,5,6,7,9,...). Check bit j sits at position 2^j,
    // and every column additionally carries the overall-parity row.
    function automatic int data_pos(input int idx);
        int pos;
        int n;
        pos = 2;
        n   = -1;
        while (n < idx) begin
            pos++;
            if ((pos & (pos - 1)) != 0) n++;
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_secded_dec.sv
// Combinational extended-Hamming SECDED decoder. Produces a correction mask
// and single/double error flags; bypass forces a clean result.
module ecc_secded_dec
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH   = 62,
    parameter int PARITY_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [PARITY_WIDTH-1:0] parity,
    input  logic                    bypass,
    output dec_res_t                res
);

    logic [DATA_WIDTH-1:0][PARITY_WIDTH-1:0] h_col;
    logic [PARITY_WIDTH-1:0]                 syn;

    // Elaboration-time H-matrix columns for the data bits
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_col
        assign h_col[i] = {1'b1, (PARITY_WIDTH-1)'(data_pos(i))};
    end

    // Syndrome: XOR of the columns of every set data and check bit
    always_comb begin
        syn = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (data[i]) syn = syn ^ h_col[i];
        for (int j = 0; j < PARITY_WIDTH - 1; j++)
            if (parity[j]) syn = syn ^ {1'b1, (PARITY_WIDTH-1)'(1 << j)};
        if (parity[PARITY_WIDTH-1]) syn = syn ^ {1'b1, {(PARITY_WIDTH-1){1'b0}}};
    end

    // Classify: odd overall parity = single error, even with a nonzero
    // position = double error. Check-bit hits flag sbit with an empty mask.
    always_comb begin
        res = '0;
        if (!bypass) begin
            res.sbit = syn[PARITY_WIDTH-1];
            res.dbit = ~syn[PARITY_WIDTH-1] & (|syn[PARITY_WIDTH-2:0]);
            for (int i = 0; i < DATA_WIDTH; i++)
                res.mask[i] = (syn == h_col[i]);
        end
    end

endmodule

// File: rtl/ecc_lockstep_chk_pipe.sv
// Two-stage lockstep SECDED checker: two identical decoders see every word;
// any disagreement is an ECC logic fault and the raw word is forwarded.
// Includes saturating event counters, sticky fault status and an interrupt.
module ecc_lockstep_chk_pipe
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH   = 62,
    parameter int PARITY_WIDTH = 8,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_vld,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    input  logic                    bypass,
    input  logic                    ecc_fault_detc_en,
    input  logic                    inj_en,
    input  logic [DATA_WIDTH-1:0]   inj_mask,
    input  logic                    stat_clr,
    output logic                    out_vld,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    sbit_err,
    output logic                    dbit_err,
    output logic                    ecc_fault,
    output logic                    fault_sticky,
    output logic                    fault_irq,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic [CNT_WIDTH-1:0]    fault_cnt
);

    localparam int STAGES = 2;
    localparam int NUM_CNT = 3;

    logic [STAGES:1]                vld_pipe;
    logic [DATA_WIDTH-1:0]          s1_data;
    logic [DATA_WIDTH-1:0]          s1_inj_mask;
    logic [PARITY_WIDTH-1:0]        s1_parity;
    logic                           s1_bypass;
    logic                           s1_en;
    logic                           s1_inj_en;
    logic [DATA_WIDTH-1:0]          dec1_data;
    dec_res_t                       res0;
    dec_res_t                       res1;
    logic                           cmp_ok;
    logic                           v1;
    logic [NUM_CNT-1:0]             evt;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt;

    assign v1      = vld_pipe[1];
    assign out_vld = vld_pipe[STAGES];

    // Valid shift register; reset drops any words in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
    end

    // Stage 1: capture the word and its controls only on accepted cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data     <= '0;
            s1_parity   <= '0;
            s1_bypass   <= 1'b0;
            s1_en       <= 1'b0;
            s1_inj_en   <= 1'b0;
            s1_inj_mask <= '0;
        end else if (in_vld) begin
            s1_data     <= data_in;
            s1_parity   <= parity_in;
            s1_bypass   <= bypass;
            s1_en       <= ecc_fault_detc_en;
            s1_inj_en   <= inj_en;
            s1_inj_mask <= inj_mask;
        end
    end

    // Injection perturbs only decoder 1 so self-test produces a mismatch
    assign dec1_data = s1_data ^ (s1_inj_en ? s1_inj_mask : '0);

    ecc_secded_dec #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec0 (
        .data   (s1_data),
        .parity (s1_parity),
        .bypass (s1_bypass),
        .res    (res0)
    );

    ecc_secded_dec #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec1 (
        .data   (dec1_data),
        .parity (s1_parity),
        .bypass (s1_bypass),
        .res    (res1)
    );

    assign cmp_ok = (res0 == res1);

    // Stage 2: corrected or raw data (held when idle), flags gated by valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            sbit_err  <= 1'b0;
            dbit_err  <= 1'b0;
            ecc_fault <= 1'b0;
        end else begin
            if (v1)
                data_out <= (cmp_ok | ~s1_en) ? (s1_data ^ res0.mask[DATA_WIDTH-1:0]) : s1_data;
            sbit_err  <= v1 & res0.sbit;
            dbit_err  <= v1 & res0.dbit;
            ecc_fault <= v1 & s1_en & ~cmp_ok;
        end
    end

    // Sticky fault with a one-shot interrupt on its rising edge; a fault
    // arriving with stat_clr keeps the sticky bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_sticky <= 1'b0;
            fault_irq    <= 1'b0;
        end else begin
            fault_sticky <= ecc_fault | (fault_sticky & ~stat_clr);
            fault_irq    <= ecc_fault & ~fault_sticky;
        end
    end

    assign evt = {ecc_fault, dbit_err, sbit_err};

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q;

        // Saturating count; a clear coinciding with an event counts that event
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                      cnt_q <= '0;
            else if (stat_clr)               cnt_q <= CNT_WIDTH'(evt[g]);
            else if (evt[g] && cnt_q != '1)  cnt_q <= cnt_q + CNT_WIDTH'(1);
        end

        assign cnt[g] = cnt_q;
    end

    assign sbit_cnt  = cnt[0];
    assign dbit_cnt  = cnt[1];
    assign fault_cnt = cnt[2];

endmodule
